// File: rtl/edge_cap_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : edge_cap_pkg                                               |
// | Description : Shared types and helpers for the edge capture unit:        |
// |               edge-select mode encoding and a 64-bit popcount.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package edge_cap_pkg;

   typedef enum logic [1:0] {
      EDGE_RISE = 2'b00,
      EDGE_FALL = 2'b01,
      EDGE_BOTH = 2'b10,
      EDGE_OFF  = 2'b11
   } edge_mode_e;

   // popcount operates on the widest legal channel vector; narrower
   // vectors are zero-extended by the caller.
   localparam int POP_IN_W  = 64;
   localparam int POP_OUT_W = 7;

   function automatic logic [POP_OUT_W-1:0] popcount(input logic [POP_IN_W-1:0] v);
      logic [POP_OUT_W-1:0] n;
      n = '0;
      for (int i = 0; i < POP_IN_W; i++) begin
         n = n + {{(POP_OUT_W-1){1'b0}}, v[i]};
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/edge_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : edge_sync                                                  |
// | Description : Multi-stage flop synchroniser, one chain per bit.          |
// |   clk   in  : sampling clock                                             |
// |   reset in  : asynchronous active-high reset, clears every stage         |
// |   d     in  : WIDTH asynchronous inputs                                  |
// |   q     out : WIDTH synchronised outputs (SYNC_STAGES cycles later)      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module edge_sync #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_d [SYNC_STAGES];
   logic [WIDTH-1:0] stage_q [SYNC_STAGES];

   always_comb begin
      stage_d[0] = d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign q = stage_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/edge_capture_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : edge_capture_unit                                          |
// | Description : Per-channel edge detector with sticky capture flags,       |
// |               read-and-clear snapshot, saturating event counter and a    |
// |               masked interrupt.                                          |
// |   clk, reset         : clock, asynchronous active-high reset            |
// |   in       [WIDTH]   : asynchronous level inputs                        |
// |   mode     [2]       : 00 rise, 01 fall, 10 both, 11 disabled           |
// |   clr_mask [WIDTH]   : per-channel capture clear                        |
// |   irq_mask [WIDTH]   : per-channel interrupt enable                     |
// |   rd_req, cnt_clr    : read-and-clear request, counter clear            |
// |   pulse, capture     : one-cycle edge pulses, sticky flags              |
// |   rd_valid, rd_data  : read response                                    |
// |   event_cnt [CNT_W]  : saturating edge count                            |
// |   irq                : registered OR of capture & irq_mask               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module edge_capture_unit
   import edge_cap_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] clr_mask,
   input  logic [WIDTH-1:0] irq_mask,
   input  logic             rd_req,
   input  logic             cnt_clr,
   output logic [WIDTH-1:0] pulse,
   output logic [WIDTH-1:0] capture,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data,
   output logic [CNT_W-1:0] event_cnt,
   output logic             irq
);

   // One spare bit above the wider of counter and popcount so the sum
   // cannot overflow before the saturation compare.
   localparam int SUM_W = ((CNT_W > POP_OUT_W) ? CNT_W : POP_OUT_W) + 1;
   localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

   logic [WIDTH-1:0]     sync_out;
   logic [WIDTH-1:0]     prev_d, prev_q;
   logic [WIDTH-1:0]     rise, fall, edge_vec;
   logic [WIDTH-1:0]     pulse_d, pulse_q;
   logic [WIDTH-1:0]     capture_d, capture_q;
   logic                 rd_valid_d, rd_valid_q;
   logic [WIDTH-1:0]     rd_data_d, rd_data_q;
   logic [CNT_W-1:0]     event_cnt_d, event_cnt_q;
   logic                 irq_d, irq_q;
   logic [POP_OUT_W-1:0] edge_pop;
   logic [SUM_W-1:0]     cnt_base, cnt_sum;

   edge_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (in),
      .q     (sync_out)
   );

   always_comb begin
      // prev keeps tracking even when disabled, so re-enabling never
      // reports a transition that happened while mode was off.
      prev_d = sync_out;
      rise   = sync_out & ~prev_q;
      fall   = ~sync_out & prev_q;

      case (edge_mode_e'(mode))
         EDGE_RISE: edge_vec = rise;
         EDGE_FALL: edge_vec = fall;
         EDGE_BOTH: edge_vec = rise | fall;
         default:   edge_vec = '0;
      endcase

      pulse_d = edge_vec;

      // Clears are applied before OR-ing in new edges so an edge in the
      // same cycle as a clear or read is never lost.
      capture_d = (capture_q & ~clr_mask & ~{WIDTH{rd_req}}) | edge_vec;

      rd_valid_d = rd_req;
      rd_data_d  = rd_req ? capture_q : rd_data_q;

      // cnt_clr restarts from zero but still counts this cycle's edges.
      edge_pop    = popcount(POP_IN_W'(edge_vec));
      cnt_base    = cnt_clr ? '0 : SUM_W'(event_cnt_q);
      cnt_sum     = cnt_base + SUM_W'(edge_pop);
      event_cnt_d = (cnt_sum > CNT_MAX) ? CNT_W'(CNT_MAX) : cnt_sum[CNT_W-1:0];

      irq_d = |(capture_d & irq_mask);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_q      <= '0;
         pulse_q     <= '0;
         capture_q   <= '0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
         event_cnt_q <= '0;
         irq_q       <= 1'b0;
      end else begin
         prev_q      <= prev_d;
         pulse_q     <= pulse_d;
         capture_q   <= capture_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
         event_cnt_q <= event_cnt_d;
         irq_q       <= irq_d;
      end
   end

   assign pulse     = pulse_q;
   assign capture   = capture_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign event_cnt = event_cnt_q;
   assign irq       = irq_q;

endmodule
`default_nettype wire
